// File: rtl/rtlmem_rdctl3x_if.sv
// Command/response handshake bundle between a client and the rtlmem_rdctl3x read controller.
// The client holds the master side; the controller holds the slave side.
interface rtlmem_rdctl3x_if #(
    parameter int G_ADDR  = 10,
    parameter int G_WIDTH = 16
);
    logic               cmd_vld;
    logic               cmd_rdy;
    logic               cmd_we;
    logic [G_ADDR-1:0]  cmd_ad;
    logic [G_WIDTH-1:0] cmd_di;
    logic               rsp_vld;
    logic               rsp_rdy;
    logic [G_WIDTH-1:0] rsp_do;

    modport master (
        output cmd_vld, cmd_we, cmd_ad, cmd_di, rsp_rdy,
        input  cmd_rdy, rsp_vld, rsp_do
    );

    modport slave (
        input  cmd_vld, cmd_we, cmd_ad, cmd_di, rsp_rdy,
        output cmd_rdy, rsp_vld, rsp_do
    );
endinterface

// File: rtl/rtlmem_rdctl3x.sv
// Client-side controller for a fixed-latency shared memory port: credit-limited read issue,
// in-flight tagging, a response FIFO, and drain-then-clear sequencing of the memory.
module rtlmem_rdctl3x #(
    parameter int G_ADDR       = 10,
    parameter int G_WIDTH      = 16,
    parameter int G_LAT        = 3,
    parameter int G_FIFO_DEPTH = 4,
    parameter int G_CLR_ON_RST = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr_req,
    output logic               clr_busy,
    rtlmem_rdctl3x_if.slave    bus,
    output logic [G_ADDR-1:0]  memad,
    output logic               memwe,
    output logic [G_WIDTH-1:0] memdi,
    output logic               memre,
    input  logic [G_WIDTH-1:0] memdo,
    output logic               memclren,
    input  logic               memclrrdy
);
    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_CLEAR} state_t;

    localparam state_t ST_RESET = (G_CLR_ON_RST != 0) ? ST_CLEAR : ST_RUN;
    localparam int     PW       = $clog2(G_FIFO_DEPTH);
    localparam int     CW       = $clog2(G_FIFO_DEPTH + 1);

    state_t             state;
    state_t             state_nxt;
    logic [CW-1:0]      credit;
    logic [CW-1:0]      inflight;
    logic [CW-1:0]      fifo_cnt;
    logic [G_LAT:0]     rd_tag;
    logic [G_WIDTH-1:0] fifo_mem [G_FIFO_DEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic               acc;
    logic               rd_acc;
    logic               push;
    logic               pop;

    assign bus.cmd_rdy = !rst && (state == ST_RUN) && (credit != '0);
    assign acc         = bus.cmd_vld && bus.cmd_rdy;
    assign rd_acc      = acc && !bus.cmd_we;
    assign push        = rd_tag[G_LAT];
    assign bus.rsp_vld = (fifo_cnt != '0);
    assign pop         = bus.rsp_vld && bus.rsp_rdy;
    assign bus.rsp_do  = fifo_mem[rd_ptr];
    assign clr_busy    = (state != ST_RUN);

    // NOTE: next-state is defaulted to the current state first so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_RUN:   if (clr_req)          state_nxt = ST_DRAIN;
            ST_DRAIN: if (inflight == '0)   state_nxt = ST_CLEAR;
            ST_CLEAR: if (memclrrdy)        state_nxt = ST_RUN;
            default:                        state_nxt = ST_RUN;
        endcase
    end

    // NOTE: all state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_RESET;
        else     state <= state_nxt;
    end

    // Memory port is registered; address/data hold between commands, strobes are one-cycle pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            memad    <= '0;
            memdi    <= '0;
            memwe    <= 1'b0;
            memre    <= 1'b0;
            memclren <= 1'b0;
        end else begin
            memwe    <= acc && bus.cmd_we;
            memre    <= rd_acc;
            memclren <= (state_nxt == ST_CLEAR);
            if (acc) begin
                memad <= bus.cmd_ad;
                memdi <= bus.cmd_di;
            end
        end
    end

    // Credits reserve a FIFO slot at issue time, so credit + inflight + fifo_cnt stays at G_FIFO_DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_tag   <= '0;
            inflight <= '0;
            credit   <= CW'(G_FIFO_DEPTH);
            fifo_cnt <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            rd_tag   <= {rd_tag[G_LAT-1:0], rd_acc};
            inflight <= inflight + CW'(rd_acc) - CW'(push);
            credit   <= credit + CW'(pop) - CW'(rd_acc);
            fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // NOTE: the FIFO array is reset on purpose: it is only a few registers and rsp_do must read zero after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < G_FIFO_DEPTH; i++) fifo_mem[i] <= '0;
        end else if (push) begin
            fifo_mem[wr_ptr] <= memdo;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && (fifo_cnt == CW'(G_FIFO_DEPTH))));
endmodule

// File: tb/tb_rtlmem_rdctl3x.sv
// Directed bench for rtlmem_rdctl3x: vector table for write/read round trips plus
// hand-written sequences for clear, backpressure, streaming, drain and mid-operation reset.
module tb_rtlmem_rdctl3x;
    localparam int AW    = 10;
    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int NV    = 9;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clr_req = 1'b0;
    logic          clr_busy;
    logic [AW-1:0] memad;
    logic          memwe;
    logic [DW-1:0] memdi;
    logic          memre;
    logic [DW-1:0] memdo;
    logic          memclren;
    logic          memclrrdy = 1'b0;

    rtlmem_rdctl3x_if #(.G_ADDR(AW), .G_WIDTH(DW)) bus ();

    rtlmem_rdctl3x #(
        .G_ADDR(AW), .G_WIDTH(DW), .G_LAT(3), .G_FIFO_DEPTH(DEPTH), .G_CLR_ON_RST(1)
    ) dut (
        .clk(clk), .rst(rst), .clr_req(clr_req), .clr_busy(clr_busy), .bus(bus),
        .memad(memad), .memwe(memwe), .memdi(memdi), .memre(memre), .memdo(memdo),
        .memclren(memclren), .memclrrdy(memclrrdy)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] pattern(input logic [AW-1:0] a);
        return {6'h2A, a};
    endfunction

    // Behavioural memory: read enable sampled at one edge, data on memdo three edges later.
    logic [DW-1:0] mem [1<<AW];
    logic [DW-1:0] p1, p2;
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < (1<<AW); i++) mem[i] <= pattern(AW'(i));
            p1    <= '0;
            p2    <= '0;
            memdo <= '0;
        end else begin
            if (memwe) mem[memad] <= memdi;
            p1    <= mem[memad];
            p2    <= p1;
            memdo <= p2;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Stream driver state shared by start()/step().
    int            rd_left;
    logic [AW-1:0] rd_addr;
    int            n_acc;
    int            n_rsp;
    logic [DW-1:0] exp_q[$];

    task automatic start(input int n, input logic [AW-1:0] base);
        rd_left = n;
        rd_addr = base;
        n_acc   = 0;
        n_rsp   = 0;
        exp_q.delete();
        bus.cmd_we  = 1'b0;
        bus.cmd_ad  = base;
        bus.cmd_vld = (n > 0);
    endtask

    // Called at a negedge: scores the handshakes of the coming edge, then advances one cycle.
    task automatic step();
        logic acc, pop;
        acc = bus.cmd_vld && bus.cmd_rdy;
        pop = bus.rsp_vld && bus.rsp_rdy;
        if (pop) begin
            check("rsp_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check("rsp_order", bus.rsp_do, exp_q.pop_front());
            n_rsp++;
        end
        if (acc) begin
            exp_q.push_back(pattern(rd_addr));
            n_acc++;
            rd_left--;
            rd_addr++;
        end
        @(posedge clk);
        @(negedge clk);
        bus.cmd_vld = (rd_left > 0);
        bus.cmd_we  = 1'b0;
        bus.cmd_ad  = rd_addr;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        logic          we;
        logic [AW-1:0] ad;
        logic [DW-1:0] di;
        logic [DW-1:0] exp_do;
    } vec_t;

    vec_t vecs[NV];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int cnt;
        bit seen;

        vecs[0] = '{1'b1, 10'd5,   16'hA5A5, 16'h0000};
        vecs[1] = '{1'b0, 10'd5,   16'h0000, 16'hA5A5};
        vecs[2] = '{1'b1, 10'd0,   16'h0001, 16'h0000};
        vecs[3] = '{1'b1, 10'h3FF, 16'hFFFF, 16'h0000};
        vecs[4] = '{1'b0, 10'h3FF, 16'h0000, 16'hFFFF};
        vecs[5] = '{1'b0, 10'd0,   16'h0000, 16'h0001};
        vecs[6] = '{1'b0, 10'd7,   16'h0000, 16'hA807};
        vecs[7] = '{1'b1, 10'd7,   16'h1234, 16'h0000};
        vecs[8] = '{1'b0, 10'd7,   16'h0000, 16'h1234};

        bus.cmd_vld = 1'b0;
        bus.cmd_we  = 1'b0;
        bus.cmd_ad  = '0;
        bus.cmd_di  = '0;
        bus.rsp_rdy = 1'b1;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_cmd_rdy",  bus.cmd_rdy, 0);
        check("rst_rsp_vld",  bus.rsp_vld, 0);
        check("rst_rsp_do",   bus.rsp_do,  0);
        check("rst_memwe",    memwe,       0);
        check("rst_memre",    memre,       0);
        check("rst_memclren", memclren,    0);
        check("rst_memad",    memad,       0);
        check("rst_clr_busy", clr_busy,    1);
        rst = 1'b0;

        // Automatic clear after reset, completed by memclrrdy after 10 cycles.
        cnt = 0;
        repeat (10) begin
            tick();
            if (memclren) cnt++;
        end
        check("clr_en_cycles", cnt, 10);
        check("clr_busy_during", clr_busy, 1);
        check("clr_cmd_rdy_low", bus.cmd_rdy, 0);
        memclrrdy = 1'b1;
        tick();
        memclrrdy = 1'b0;
        check("clr_en_fall", memclren, 0);
        check("clr_busy_fall", clr_busy, 0);
        check("run_cmd_rdy", bus.cmd_rdy, 1);

        // Vector table: writes check the memory port, reads check latency and data.
        for (int i = 0; i < NV; i++) begin
            bus.cmd_we  = vecs[i].we;
            bus.cmd_ad  = vecs[i].ad;
            bus.cmd_di  = vecs[i].di;
            bus.cmd_vld = 1'b1;
            n = 0;
            while (!bus.cmd_rdy && n < 20) begin
                tick();
                n++;
            end
            check("vec_cmd_rdy", bus.cmd_rdy, 1);
            tick();
            bus.cmd_vld = 1'b0;
            check("vec_memad", memad, vecs[i].ad);
            check("vec_memwe", memwe, vecs[i].we);
            check("vec_memre", memre, !vecs[i].we);
            if (vecs[i].we) begin
                check("vec_memdi", memdi, vecs[i].di);
            end else begin
                n = 0;
                while (!bus.rsp_vld && n < 10) begin
                    tick();
                    n++;
                end
                check("vec_rd_latency", n, 4);
                check("vec_rsp_do", bus.rsp_do, vecs[i].exp_do);
                tick();
                check("vec_rsp_popped", bus.rsp_vld, 0);
            end
        end
        tick();
        check("idle_memwe", memwe, 0);
        check("idle_memre", memre, 0);

        // Backpressure: six reads offered, only four credits.
        bus.rsp_rdy = 1'b0;
        start(6, 10'h10);
        repeat (12) step();
        check("bp_accepted", n_acc, 4);
        check("bp_cmd_rdy", bus.cmd_rdy, 0);
        check("bp_rsp_vld", bus.rsp_vld, 1);
        check("bp_head_held", bus.rsp_do, pattern(10'h10));
        check("bp_no_rsp", n_rsp, 0);
        bus.rsp_rdy = 1'b1;
        n = 0;
        while (n_rsp < 6 && n < 60) begin
            step();
            n++;
        end
        check("bp_total_acc", n_acc, 6);
        check("bp_total_rsp", n_rsp, 6);

        // Streaming reads with the consumer always ready.
        start(20, 10'h40);
        repeat (4) step();
        check("stream_first4", n_acc, 4);
        n = 0;
        while (n_rsp < 20 && n < 200) begin
            step();
            n++;
        end
        check("stream_acc", n_acc, 20);
        check("stream_rsp", n_rsp, 20);

        // Clear requested with two reads in flight: clear waits for both to land.
        bus.rsp_rdy = 1'b0;
        start(2, 10'h80);
        repeat (2) step();
        check("drain_acc", n_acc, 2);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        check("drain_busy", clr_busy, 1);
        check("drain_cmd_rdy", bus.cmd_rdy, 0);
        check("drain_no_clr", memclren, 0);
        n = 0;
        while (!memclren && n < 20) begin
            tick();
            n++;
        end
        check("drain_clr_delay", n, 4);
        check("drain_fifo_held", bus.rsp_vld, 1);
        memclrrdy = 1'b1;
        tick();
        memclrrdy = 1'b0;
        check("drain_clr_done", clr_busy, 0);
        bus.rsp_rdy = 1'b1;
        n = 0;
        while (n_rsp < 2 && n < 20) begin
            step();
            n++;
        end
        check("drain_rsp", n_rsp, 2);

        // Reset right after a read accept: the read is discarded and credits restored.
        start(1, 10'h3);
        step();
        check("mid_memre_pre", memre, 1);
        rst = 1'b1;
        #1;
        check("mid_memre_rst", memre, 0);
        check("mid_rsp_vld_rst", bus.rsp_vld, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        n = 0;
        while (!memclren && n < 20) begin
            tick();
            n++;
            seen |= bus.rsp_vld;
        end
        check("mid_clr_start", memclren, 1);
        memclrrdy = 1'b1;
        tick();
        memclrrdy = 1'b0;
        repeat (6) begin
            tick();
            seen |= bus.rsp_vld;
        end
        check("mid_no_rsp", seen, 0);
        bus.rsp_rdy = 1'b0;
        start(6, 10'h20);
        repeat (10) step();
        check("mid_credit_acc", n_acc, 4);
        check("mid_credit_rdy", bus.cmd_rdy, 0);
        bus.rsp_rdy = 1'b1;
        n = 0;
        while (n_rsp < 6 && n < 60) begin
            step();
            n++;
        end
        check("mid_total_rsp", n_rsp, 6);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
